// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-access and shared single-port memory signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        flush;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        stall_if;
    logic        stall_mem;

    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, flush,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  ram_rdata,
        output if_inst, if_ready, mem_rdata, mem_ready,
        output stall_if, stall_mem,
        output ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
    );

    modport master (
        output if_req, if_addr, flush,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output ram_rdata,
        input  if_inst, if_ready, mem_rdata, mem_ready,
        input  stall_if, stall_mem,
        input  ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory with a fixed
// access latency of LAT cycles; grants alternate when both sides keep requesting.
module mem_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("mem_arbiter: LAT must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;
    typedef enum logic {GRANT_IF, GRANT_MEM} grant_t;

    state_t      state;
    state_t      state_next;
    grant_t      last_grant;
    logic [3:0]  count;
    logic        cancel;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] rdata_q;
    logic [31:0] inst_hold;
    logic [31:0] rdata_hold;

    logic        fetch_ok;
    logic        grant_mem;
    logic        grant_fetch;
    logic        busy;
    logic        if_ready_w;
    logic        mem_ready_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision, access sequencing and all combinational outputs.
    // last_grant names the requester of the access currently in DONE.
    always_comb begin
        state_next  = state;
        grant_mem   = 1'b0;
        grant_fetch = 1'b0;
        fetch_ok    = bus.if_req && !bus.flush;

        case (state)
            IDLE: begin
                if (bus.mem_req && fetch_ok) begin
                    if (last_grant == GRANT_MEM) begin
                        grant_fetch = 1'b1;
                    end else begin
                        grant_mem = 1'b1;
                    end
                end else if (bus.mem_req) begin
                    grant_mem = 1'b1;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                end
                if (grant_mem) begin
                    state_next = MEM_BUSY;
                end else if (grant_fetch) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy        = (state == IF_BUSY) || (state == MEM_BUSY);
        if_ready_w  = (state == DONE) && (last_grant == GRANT_IF) && !cancel && !bus.flush;
        mem_ready_w = (state == DONE) && (last_grant == GRANT_MEM);

        bus.ram_ce    = busy;
        bus.ram_we    = busy && we_q;
        bus.ram_addr  = busy ? addr_q  : 32'h0;
        bus.ram_wdata = busy ? wdata_q : 32'h0;
        bus.ram_sel   = busy ? sel_q   : 4'h0;

        bus.if_ready  = if_ready_w;
        bus.mem_ready = mem_ready_w;
        bus.if_inst   = if_ready_w  ? rdata_q : inst_hold;
        bus.mem_rdata = mem_ready_w ? rdata_q : rdata_hold;

        // Stalls are gated by reset so every output is quiet while reset is held.
        bus.stall_if  = rst && bus.if_req  && !if_ready_w;
        bus.stall_mem = rst && bus.mem_req && !mem_ready_w;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_IF;
            count      <= 4'd0;
            cancel     <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            rdata_q    <= 32'h0;
            inst_hold  <= 32'h0;
            rdata_hold <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (grant_mem) begin
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        we_q    <= bus.mem_we;
                        sel_q   <= bus.mem_sel;
                        count   <= 4'(LAT - 1);
                    end else if (grant_fetch) begin
                        addr_q  <= bus.if_addr;
                        wdata_q <= 32'h0;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        count   <= 4'(LAT - 1);
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (state == IF_BUSY && bus.flush) begin
                        cancel <= 1'b1;
                    end
                    if (count == 4'd0) begin
                        rdata_q    <= we_q ? 32'h0 : bus.ram_rdata;
                        last_grant <= (state == IF_BUSY) ? GRANT_IF : GRANT_MEM;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    cancel <= 1'b0;
                    if (if_ready_w) begin
                        inst_hold <= rdata_q;
                    end
                    if (mem_ready_w) begin
                        rdata_hold <= rdata_q;
                    end
                end
                default: begin
                    cancel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2, memory access latency in cycles; the legal range SHALL be 1..15.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 if_req  input  1  fetch request, held until if_ready or flush.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_inst  output  32  fetched instruction, valid when if_ready=1.
REQ-007 if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 flush  input  1  pipeline flush; cancels delivery of the pending fetch.
REQ-009 mem_req  input  1  data access request, held until mem_ready.
REQ-010 mem_we  input  1  1=store, 0=load.
REQ-011 mem_addr  input  32  data byte address.
REQ-012 mem_wdata  input  32  store data.
REQ-013 mem_sel  input  4  byte lane enables.
REQ-014 mem_rdata  output  32  load data, valid when mem_ready=1.
REQ-015 mem_ready  output  1  one-cycle data completion pulse.
REQ-016 stall_if, stall_mem  output  1 each  stall requests to pipeline control.
REQ-017 ram_ce, ram_we  output  1 each  shared single-port memory chip enable and write enable.
REQ-018 ram_addr, ram_wdata  output  32 each  shared memory address and write data.
REQ-019 ram_sel  output  4  shared memory byte enables.
REQ-020 ram_rdata  input  32  shared memory read data.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, IF_BUSY, MEM_BUSY and DONE.
REQ-022 In IDLE, the arbiter SHALL grant at the clock edge on which at least one request is high, then latch the granted address, data, we and sel, and load the counter with LAT-1.
REQ-023 Priority SHALL go to MEM, except when both requests are high and last_grant=MEM, in which case IF SHALL win (alternating grants, so neither requester starves).
REQ-024 In IF_BUSY and MEM_BUSY, the arbiter SHALL drive ram_ce=1 and drive ram_addr, ram_we, ram_wdata and ram_sel from the latched values for exactly LAT cycles.
REQ-025 In IF_BUSY, ram_we SHALL be 0 and ram_sel SHALL be 4'b1111.
REQ-026 In any state other than the busy states, all ram_* outputs SHALL be 0.
REQ-027 When the counter is 0 in a busy state, the arbiter SHALL capture ram_rdata at the next edge, enter DONE and update last_grant.
REQ-028 In DONE, the arbiter SHALL pulse the granted requester's ready for one cycle.
REQ-029 In DONE, if_inst or mem_rdata SHALL present the captured data; mem_rdata SHALL be 0 for stores.
REQ-030 DONE SHALL grant nothing and SHALL return to IDLE, so a request that is still held is never served twice.
REQ-031 Request-to-ready latency SHALL be LAT+1 cycles when the arbiter is idle; the access period SHALL be LAT+2 cycles.
REQ-032 if_inst and mem_rdata SHALL hold their last values when ready is 0.
REQ-033 stall_if SHALL equal if_req AND NOT if_ready, and stall_mem SHALL equal mem_req AND NOT mem_ready, both combinationally.
REQ-034 flush during IF_BUSY SHALL set a cancel flag; the memory access still completes, but if_ready SHALL stay 0 in DONE and if_inst SHALL remain unchanged.
REQ-035 flush asserted in DONE of an IF access SHALL suppress the if_ready pulse.
REQ-036 flush SHALL NOT affect MEM accesses.
REQ-037 The cancel flag SHALL clear on entry to IDLE.
REQ-038 flush in IDLE SHALL block a fetch grant in that cycle; MEM may still be granted.
REQ-039 Request or address changes while busy SHALL be ignored, because the latched values are used.

Reset
REQ-040 On rst=0, the arbiter SHALL go immediately to IDLE and force all outputs to 0, independent of clk, including in the middle of an access.
REQ-041 On rst=0, last_grant SHALL be set to IF (so MEM wins first), and the counter and cancel flag SHALL be set to 0.
REQ-042 After rst is released, the first grant SHALL occur no earlier than the first rising edge.

Verification (LAT=2, cycle 0 = request first seen in IDLE)
REQ-043 Fetch only: if_req=1 with if_addr=0x00000004, and ram_rdata=0x3C010001 -> ram_ce=1 and ram_addr=0x4 in cycles 1-2; if_ready=1 and if_inst=0x3C010001 in cycle 3; stall_if=1 in cycles 0-2.
REQ-044 Simultaneous requests after reset (load 0x100; fetch 0x8) -> MEM is busy in cycles 1-2 with mem_ready in cycle 3; IF is busy in cycles 5-6 with if_ready in cycle 7.
REQ-045 Both requests held across 4 accesses -> grant order MEM, IF, MEM, IF.
REQ-046 Store: mem_we=1, mem_sel=4'b0011, mem_addr=0x200, mem_wdata=0xDEADBEEF -> ram_we=1 and ram_sel=0011 in cycles 1-2; mem_ready=1 and mem_rdata=0 in cycle 3.
REQ-047 flush=1 in cycle 2 of a fetch -> no if_ready pulse; the FSM is in IDLE in cycle 4; a MEM request raised in cycle 4 is granted normally.
REQ-048 rst=0 mid-way through cycle 1 of MEM_BUSY -> ram_ce, stall_mem and mem_ready go to 0 without waiting for clk; after release, a re-issued mem_req completes in LAT+1 cycles.
